// File: rtl/fibo_ctrl.sv
// fibo_ctrl: Fibonacci sequencer driving an external fnselect ALU.
//
// Computes F(n) mod 2^WIDTH by issuing one ALU operation per cycle and
// latching the ALU result into the A/B/T/cnt working registers.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only in IDLE
//   n       Fibonacci index, captured when start is accepted
//   alu_fn  ALU function select (000 x, 001 y, 010 one, 011 x-1, 100 x+y)
//   alu_x   ALU operand x
//   alu_y   ALU operand y
//   alu_z   combinational ALU result
//   busy    high while computing (not IDLE, not DONE)
//   done    one-cycle pulse when result is valid
//   result  F(n) mod 2^WIDTH, held until the next DONE
//   ovf     sticky wrap flag, cleared when start is accepted
module fibo_ctrl #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned FN_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic [FN_W-1:0]  alu_fn,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LOAD  = 4'd1;
    localparam logic [3:0] ST_INITB = 4'd2;
    localparam logic [3:0] ST_INITA = 4'd3;
    localparam logic [3:0] ST_CHECK = 4'd4;
    localparam logic [3:0] ST_ADD   = 4'd5;
    localparam logic [3:0] ST_SHIFT = 4'd6;
    localparam logic [3:0] ST_MOVE  = 4'd7;
    localparam logic [3:0] ST_DEC   = 4'd8;
    localparam logic [3:0] ST_DONE  = 4'd9;

    localparam logic [FN_W-1:0] FN_PASS_X = FN_W'(0);
    localparam logic [FN_W-1:0] FN_PASS_Y = FN_W'(1);
    localparam logic [FN_W-1:0] FN_ONE    = FN_W'(2);
    localparam logic [FN_W-1:0] FN_DEC    = FN_W'(3);
    localparam logic [FN_W-1:0] FN_ADD    = FN_W'(4);

    logic [3:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    // ALU command decode: purely a function of the current state.
    always_comb begin
        alu_fn = FN_PASS_X;
        alu_x  = '0;
        alu_y  = '0;
        case (state_q)
            ST_LOAD:  alu_x = n_q;
            ST_INITB: alu_fn = FN_ONE;
            ST_INITA: begin
                alu_fn = FN_DEC;
                alu_x  = b_q;
            end
            ST_CHECK: alu_x = cnt_q;
            ST_ADD: begin
                alu_fn = FN_ADD;
                alu_x  = a_q;
                alu_y  = b_q;
            end
            ST_SHIFT: begin
                alu_fn = FN_PASS_Y;
                alu_y  = b_q;
            end
            ST_MOVE:  alu_x = t_q;
            ST_DEC: begin
                alu_fn = FN_DEC;
                alu_x  = cnt_q;
            end
            default: ;
        endcase
    end

    // Next-state and register loads; each load captures alu_z on leaving the state.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = n;
                    ovf_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = alu_z;
                state_d = ST_INITB;
            end
            ST_INITB: begin
                b_d     = alu_z;
                state_d = ST_INITA;
            end
            ST_INITA: begin
                a_d     = alu_z;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cnt_q == '0) begin
                    result_d = a_q;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                t_d = alu_z;
                // A sum smaller than one addend means the addition wrapped.
                if (alu_z < a_q) begin
                    ovf_d = 1'b1;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_d     = alu_z;
                state_d = ST_MOVE;
            end
            ST_MOVE: begin
                b_d     = alu_z;
                state_d = ST_DEC;
            end
            ST_DEC: begin
                cnt_d   = alu_z;
                state_d = ST_CHECK;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_fibo_ctrl.sv
// tb_fibo_ctrl: directed bench for fibo_ctrl with a behavioural ALU model.
module tb_fibo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] n;
    logic [2:0] alu_fn;
    logic [9:0] alu_x;
    logic [9:0] alu_y;
    logic [9:0] alu_z;
    logic       busy;
    logic       done;
    logic [9:0] result;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    logic [2:0] trace [0:15];
    bit         busy_bad;

    fibo_ctrl #(.WIDTH(10), .FN_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .n      (n),
        .alu_fn (alu_fn),
        .alu_x  (alu_x),
        .alu_y  (alu_y),
        .alu_z  (alu_z),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    // Behavioural ALU.
    always_comb begin
        case (alu_fn)
            3'b000:  alu_z = alu_x;
            3'b001:  alu_z = alu_y;
            3'b010:  alu_z = 10'd1;
            3'b011:  alu_z = alu_x - 10'd1;
            3'b100:  alu_z = alu_x + alu_y;
            default: alu_z = 10'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts cycles after the accepting edge until done is seen; lat = L means
    // done is high in the cycle after edge k+L.
    task automatic wait_done(output int lat);
        lat = -1;
        busy_bad = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (i < 16) trace[i] = alu_fn;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_bad = 1'b1;
        end
        if (lat < 0) check("timeout", 32'd1, 32'd0);
    endtask

    // Start a run with index nv, then scramble n to show it is not reused.
    task automatic run(input logic [9:0] nv, output int lat);
        @(negedge clk);
        start = 1'b1;
        n     = nv;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 10'($urandom);
        wait_done(lat);
    endtask

    int lat;
    int pulses;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        n     = 10'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_fn", 32'(alu_fn), 32'd0);
        check("rst_x", 32'(alu_x), 32'd0);
        check("rst_y", 32'(alu_y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // n=0
        run(10'd0, lat);
        check("n0_lat", 32'(lat), 32'd4);
        check("n0_result", 32'(result), 32'd0);
        check("n0_ovf", 32'(ovf), 32'd0);
        check("n0_busy_in_done", 32'(busy), 32'd0);

        // n=1 with op trace from LOAD through the final CHECK
        run(10'd1, lat);
        check("n1_lat", 32'(lat), 32'd9);
        check("n1_result", 32'(result), 32'd1);
        check("n1_fn_load", 32'(trace[0]), 32'd0);
        check("n1_fn_initb", 32'(trace[1]), 32'd2);
        check("n1_fn_inita", 32'(trace[2]), 32'd3);
        check("n1_fn_check", 32'(trace[3]), 32'd0);
        check("n1_fn_add", 32'(trace[4]), 32'd4);
        check("n1_fn_shift", 32'(trace[5]), 32'd1);
        check("n1_fn_move", 32'(trace[6]), 32'd0);
        check("n1_fn_dec", 32'(trace[7]), 32'd3);
        check("n1_fn_check2", 32'(trace[8]), 32'd0);
        @(negedge clk);
        check("n1_done_pulse", 32'(done), 32'd0);
        check("n1_result_held", 32'(result), 32'd1);

        // n=10
        run(10'd10, lat);
        check("n10_lat", 32'(lat), 32'd54);
        check("n10_result", 32'(result), 32'h037);
        check("n10_ovf", 32'(ovf), 32'd0);
        check("n10_busy_run", 32'(busy_bad), 32'd0);

        // largest index whose computation never wraps
        run(10'd15, lat);
        check("n15_result", 32'(result), 32'd610);
        check("n15_ovf", 32'(ovf), 32'd0);

        run(10'd16, lat);
        check("n16_result", 32'(result), 32'd987);

        run(10'd17, lat);
        check("n17_result", 32'(result), 32'd573);
        check("n17_ovf", 32'(ovf), 32'd1);

        run(10'd5, lat);
        check("n5_result", 32'(result), 32'd5);
        check("n5_ovf", 32'(ovf), 32'd0);

        // n=20 aborted by reset during the second CHECK (after edge k+8)
        @(negedge clk);
        start = 1'b1;
        n     = 10'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_fn", 32'(alu_fn), 32'd0);
        check("abort_x", 32'(alu_x), 32'd0);
        @(negedge clk);
        check("abort_done_hold", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);

        run(10'd3, lat);
        check("n3_lat", 32'(lat), 32'd19);
        check("n3_result", 32'(result), 32'd2);

        // start held high through a run of n=7
        @(negedge clk);
        start = 1'b1;
        n     = 10'd7;
        @(posedge clk);
        pulses = 0;
        lat = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                lat = i;
                break;
            end
        end
        check("held_lat", 32'(lat), 32'd39);
        check("held_result", 32'(result), 32'd13);
        @(negedge clk);
        if (done) pulses++;
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat);
        check("held2_lat", 32'(lat), 32'd38);
        check("held2_result", 32'(result), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
